// File: rtl/ex_muldiv.sv
// rtl/ex_muldiv.sv - iterative RV64M multiply/divide unit for the execute stage; word ops enabled by YSYX22040228_MULDIV_WORD_EN
module ex_muldiv #(
  parameter int XLEN     = 64,
  parameter int MUL_BITS = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [3:0]      req_op,
  input  logic [XLEN-1:0] req_op1,
  input  logic [XLEN-1:0] req_op2,
  input  logic [4:0]      req_rd_addr,
  input  logic            flush,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_data,
  output logic [4:0]      resp_rd_addr,
  output logic            busy
);

  localparam int CW = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_DONE
  } state_t;

  state_t state_q, state_d;

  // Iteration state. x_q holds the multiplier (consumed LSB first) or the
  // dividend, which is shifted out MSB first while quotient bits shift in.
  logic [2*XLEN-1:0] acc_q;
  logic [2*XLEN-1:0] mcand_q;
  logic [XLEN-1:0]   x_q;
  logic [XLEN-1:0]   y_q;
  logic [XLEN-1:0]   rem_q;
  logic [CW-1:0]     cnt_q;
  logic              neg_q;
  logic              neg_r_q;
  logic              high_q;
  logic              rem_sel_q;
`ifdef YSYX22040228_MULDIV_WORD_EN
  logic              word_q;
  logic              dec_word;
  logic              res_word;
`endif

  // Request decode.
  logic              dec_legal;
  logic              dec_mul;
  logic              dec_rem;
  logic              dec_high;
  logic              dec_a_signed;
  logic              dec_b_signed;
  logic              dec_special;
  logic [XLEN-1:0]   a_raw;
  logic [XLEN-1:0]   b_raw;
  logic [XLEN-1:0]   a_mag;
  logic [XLEN-1:0]   b_mag;
  logic              a_neg;
  logic              b_neg;
  logic              div_zero;
  logic              div_ovf;
  logic [XLEN-1:0]   min_neg_eff;
  logic [XLEN-1:0]   dividend_init;
  logic [XLEN-1:0]   spec_pre;
  logic [CW-1:0]     iter_mul;
  logic [CW-1:0]     iter_div;
  logic [CW-1:0]     iter_init;

  // Datapath step and result.
  logic [2*XLEN-1:0] mul_sum;
  logic [2*XLEN-1:0] prod_fin;
  logic [XLEN:0]     trial;
  logic              q_bit;
  logic [XLEN-1:0]   rem_nxt;
  logic [XLEN-1:0]   quot_nxt;
  logic [XLEN-1:0]   quot_fin;
  logic [XLEN-1:0]   rem_fin;
  logic [XLEN-1:0]   iter_res;
  logic [XLEN-1:0]   res_pre;
  logic [XLEN-1:0]   res_fin;

  // Handshake/control.
  logic              accept;
  logic              last_iter;
  logic              go_done;

  // Decode the incoming op, form operand magnitudes and detect divide special cases.
  always_comb begin
    dec_mul      = !req_op[2];
    dec_rem      = req_op[2] & req_op[1];
    dec_high     = !req_op[2] & (req_op[1:0] != 2'd0);
    dec_a_signed = (req_op[2:0] == 3'd1) | (req_op[2:0] == 3'd2) | (req_op[2] & !req_op[0]);
    dec_b_signed = (req_op[2:0] == 3'd1) | (req_op[2] & !req_op[0]);
`ifdef YSYX22040228_MULDIV_WORD_EN
    dec_word  = req_op[3];
    dec_legal = !(req_op[3] & !req_op[2] & (req_op[1:0] != 2'd0));
    if (dec_word) begin
      a_raw       = dec_a_signed ? {{(XLEN-32){req_op1[31]}}, req_op1[31:0]}
                                 : {{(XLEN-32){1'b0}}, req_op1[31:0]};
      b_raw       = dec_b_signed ? {{(XLEN-32){req_op2[31]}}, req_op2[31:0]}
                                 : {{(XLEN-32){1'b0}}, req_op2[31:0]};
      min_neg_eff = {{(XLEN-31){1'b1}}, 31'd0};
      iter_mul    = CW'(32 / MUL_BITS);
      iter_div    = CW'(32);
    end else begin
      a_raw       = req_op1;
      b_raw       = req_op2;
      min_neg_eff = MIN_NEG;
      iter_mul    = CW'(XLEN / MUL_BITS);
      iter_div    = CW'(XLEN);
    end
`else
    dec_legal   = !req_op[3];
    a_raw       = req_op1;
    b_raw       = req_op2;
    min_neg_eff = MIN_NEG;
    iter_mul    = CW'(XLEN / MUL_BITS);
    iter_div    = CW'(XLEN);
`endif
    a_neg    = dec_a_signed & a_raw[XLEN-1];
    b_neg    = dec_b_signed & b_raw[XLEN-1];
    a_mag    = a_neg ? -a_raw : a_raw;
    b_mag    = b_neg ? -b_raw : b_raw;
    div_zero = (b_raw == '0);
    div_ovf  = dec_a_signed & dec_b_signed & (a_raw == min_neg_eff) & (b_raw == '1);
    dec_special = dec_legal & !dec_mul & (div_zero | div_ovf);

    // Word divides start with the 32-bit dividend parked in the top half so
    // the same MSB-first shifter serves both widths.
`ifdef YSYX22040228_MULDIV_WORD_EN
    dividend_init = dec_word ? {a_mag[31:0], {(XLEN-32){1'b0}}} : a_mag;
`else
    dividend_init = a_mag;
`endif
    iter_init = dec_mul ? iter_mul : iter_div;

    if (!dec_legal) begin
      spec_pre = '0;
    end else if (div_zero) begin
      spec_pre = dec_rem ? a_raw : '1;
    end else begin
      spec_pre = dec_rem ? '0 : a_raw;
    end
  end

  // One shift-add multiply step, one restoring divide step, and exit sign fix-up.
  always_comb begin
    mul_sum = acc_q;
    for (int i = 0; i < MUL_BITS; i++) begin
      if (x_q[i]) begin
        mul_sum = mul_sum + (mcand_q << i);
      end
    end
    prod_fin = neg_q ? -mul_sum : mul_sum;

    trial    = {rem_q, x_q[XLEN-1]} - {1'b0, y_q};
    q_bit    = !trial[XLEN];
    rem_nxt  = q_bit ? trial[XLEN-1:0] : {rem_q[XLEN-2:0], x_q[XLEN-1]};
    quot_nxt = {x_q[XLEN-2:0], q_bit};
    quot_fin = neg_q ? -quot_nxt : quot_nxt;
    rem_fin  = neg_r_q ? -rem_nxt : rem_nxt;

    if (state_q == ST_MUL) begin
      iter_res = high_q ? prod_fin[2*XLEN-1:XLEN] : prod_fin[XLEN-1:0];
    end else begin
      iter_res = rem_sel_q ? rem_fin : quot_fin;
    end

    res_pre = (state_q == ST_IDLE) ? spec_pre : iter_res;
`ifdef YSYX22040228_MULDIV_WORD_EN
    res_word = (state_q == ST_IDLE) ? dec_word : word_q;
    res_fin  = res_word ? {{(XLEN-32){res_pre[31]}}, res_pre[31:0]} : res_pre;
`else
    res_fin  = res_pre;
`endif
  end

  // Next-state logic and handshake outputs; flush overrides everything but reset.
  always_comb begin
    state_d    = state_q;
    req_ready  = (state_q == ST_IDLE) && !rst;
    busy       = (state_q != ST_IDLE);
    resp_valid = (state_q == ST_DONE);
    accept     = req_valid && req_ready && !flush;
    last_iter  = (cnt_q == CW'(1));
    go_done    = !dec_legal || dec_special;
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            if (go_done) begin
              state_d = ST_DONE;
            end else if (dec_mul) begin
              state_d = ST_MUL;
            end else begin
              state_d = ST_DIV;
            end
          end
        end
        ST_MUL, ST_DIV: begin
          if (last_iter) begin
            state_d = ST_DONE;
          end
        end
        ST_DONE: begin
          if (resp_ready) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Operand capture on accept, per-cycle iteration, result capture on entry to DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_data    <= '0;
      resp_rd_addr <= '0;
      acc_q        <= '0;
      mcand_q      <= '0;
      x_q          <= '0;
      y_q          <= '0;
      rem_q        <= '0;
      cnt_q        <= '0;
      neg_q        <= 1'b0;
      neg_r_q      <= 1'b0;
      high_q       <= 1'b0;
      rem_sel_q    <= 1'b0;
`ifdef YSYX22040228_MULDIV_WORD_EN
      word_q       <= 1'b0;
`endif
    end else if (!flush) begin
      if (accept) begin
        resp_rd_addr <= req_rd_addr;
        acc_q        <= '0;
        mcand_q      <= {{XLEN{1'b0}}, a_mag};
        x_q          <= dec_mul ? b_mag : dividend_init;
        y_q          <= b_mag;
        rem_q        <= '0;
        cnt_q        <= iter_init;
        neg_q        <= a_neg ^ b_neg;
        neg_r_q      <= a_neg;
        high_q       <= dec_high;
        rem_sel_q    <= dec_rem;
`ifdef YSYX22040228_MULDIV_WORD_EN
        word_q       <= dec_word;
`endif
        if (go_done) begin
          resp_data <= res_fin;
        end
      end else if (state_q == ST_MUL) begin
        acc_q   <= mul_sum;
        mcand_q <= mcand_q << MUL_BITS;
        x_q     <= x_q >> MUL_BITS;
        cnt_q   <= cnt_q - 1'b1;
        if (last_iter) begin
          resp_data <= res_fin;
        end
      end else if (state_q == ST_DIV) begin
        rem_q <= rem_nxt;
        x_q   <= quot_nxt;
        cnt_q <= cnt_q - 1'b1;
        if (last_iter) begin
          resp_data <= res_fin;
        end
      end
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// tb/tb_ex_muldiv.sv - randomized self-checking bench for ex_muldiv against a behavioural model
module tb_ex_muldiv;

  localparam int XLEN = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic            req_valid;
  logic [3:0]      req_op;
  logic [XLEN-1:0] req_op1;
  logic [XLEN-1:0] req_op2;
  logic [4:0]      req_rd_addr;
  logic            flush;
  logic            resp_ready;

  logic            req_ready,    req_ready4;
  logic            resp_valid,   resp_valid4;
  logic [XLEN-1:0] resp_data,    resp_data4;
  logic [4:0]      resp_rd_addr, resp_rd_addr4;
  logic            busy,         busy4;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ex_muldiv #(.XLEN(XLEN), .MUL_BITS(1)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_op1(req_op1), .req_op2(req_op2), .req_rd_addr(req_rd_addr), .flush(flush),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_rd_addr(resp_rd_addr), .busy(busy)
  );

  ex_muldiv #(.XLEN(XLEN), .MUL_BITS(4)) u_dut_mb4 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready4), .req_op(req_op),
    .req_op1(req_op1), .req_op2(req_op2), .req_rd_addr(req_rd_addr), .flush(flush),
    .resp_valid(resp_valid4), .resp_ready(resp_ready), .resp_data(resp_data4),
    .resp_rd_addr(resp_rd_addr4), .busy(busy4)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  function automatic bit legal_op(input logic [3:0] op);
`ifdef YSYX22040228_MULDIV_WORD_EN
    return !(op == 4'd9 || op == 4'd10 || op == 4'd11);
`else
    return !op[3];
`endif
  endfunction

  function automatic logic [63:0] model_res(input logic [3:0] op, input logic [63:0] a,
                                            input logic [63:0] b);
    logic signed [127:0] pa, pb;
    logic [127:0]        pp;
    logic signed [63:0]  sa, sb, sq;
    logic signed [31:0]  wa, wb, wq;
    logic [31:0]         ua, ub, uq;
    bit                  ovf64, ovf32;
    sa = a; sb = b; wa = a[31:0]; wb = b[31:0]; ua = a[31:0]; ub = b[31:0];
    ovf64 = (a == 64'h8000_0000_0000_0000) && (b == 64'hFFFF_FFFF_FFFF_FFFF);
    ovf32 = (ua == 32'h8000_0000) && (ub == 32'hFFFF_FFFF);
    if (!legal_op(op)) return 64'd0;
    case (op)
      4'd0: return a * b;
      4'd1: begin pa = sa; pb = sb; pp = pa * pb; return pp[127:64]; end
      4'd2: begin pa = sa; pb = $signed({64'd0, b}); pp = pa * pb; return pp[127:64]; end
      4'd3: begin pp = {64'd0, a} * {64'd0, b}; return pp[127:64]; end
      4'd4: begin
        if (b == 0) return '1;
        if (ovf64) return a;
        sq = sa / sb; return sq;
      end
      4'd5: begin if (b == 0) return '1; return a / b; end
      4'd6: begin
        if (b == 0) return a;
        if (ovf64) return 64'd0;
        sq = sa % sb; return sq;
      end
      4'd7: begin if (b == 0) return a; return a % b; end
      4'd8: begin uq = ua * ub; return sext32(uq); end
      4'd12: begin
        if (ub == 0) return '1;
        if (ovf32) return sext32(ua);
        wq = wa / wb; return sext32(wq);
      end
      4'd13: begin if (ub == 0) return '1; uq = ua / ub; return sext32(uq); end
      4'd14: begin
        if (ub == 0) return sext32(ua);
        if (ovf32) return 64'd0;
        wq = wa % wb; return sext32(wq);
      end
      4'd15: begin if (ub == 0) return sext32(ua); uq = ua % ub; return sext32(uq); end
      default: return 64'd0;
    endcase
  endfunction

  function automatic int model_lat(input logic [3:0] op, input logic [63:0] a,
                                   input logic [63:0] b, input int mb);
    bit word, sgn, zero, ovf;
    word = op[3];
    sgn  = !op[0];
    if (!legal_op(op)) return 1;
    if (!op[2]) return (word ? 32 : 64) / mb + 1;
    zero = word ? (b[31:0] == 32'd0) : (b == 64'd0);
    ovf  = sgn && (word ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                        : (a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF));
    if (zero || ovf) return 1;
    return word ? 33 : 65;
  endfunction

  function automatic logic [63:0] pick();
    logic [63:0] v;
    case ($urandom_range(0, 6))
      0: v = 64'd0;
      1: v = 64'hFFFF_FFFF_FFFF_FFFF;
      2: v = 64'h8000_0000_0000_0000;
      3: begin
        v = 64'($urandom_range(0, 20));
        if ($urandom_range(0, 1) == 1) v = -v;
      end
      4: v = {32'($urandom), 32'h8000_0000};
      default: v = {32'($urandom), 32'($urandom)};
    endcase
    return v;
  endfunction

  // Called at a negedge with the DUTs idle; returns at the negedge after the response handshake.
  task automatic run_op(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                        input logic [4:0] rd, input logic [63:0] exp_d,
                        input int lat1, input int lat4, input int hold);
    int cyc, c1, c4;
    check("ready_before", 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_op = op; req_op1 = a; req_op2 = b; req_rd_addr = rd;
    @(negedge clk);
    req_valid = 1'b0;
    req_op = 4'($urandom); req_op1 = {32'($urandom), 32'($urandom)};
    req_op2 = {32'($urandom), 32'($urandom)}; req_rd_addr = 5'($urandom);
    check("busy_c1", 64'(busy), 64'd1);
    check("busy4_c1", 64'(busy4), 64'd1);
    cyc = 1; c1 = -1; c4 = -1;
    while ((c1 < 0 || c4 < 0) && cyc < 200) begin
      if (c1 < 0 && resp_valid) c1 = cyc;
      if (c4 < 0 && resp_valid4) c4 = cyc;
      if (c1 < 0 || c4 < 0) begin
        @(negedge clk);
        cyc++;
      end
    end
    check($sformatf("lat op%0d", op), 64'(c1), 64'(lat1));
    check($sformatf("lat_mb4 op%0d", op), 64'(c4), 64'(lat4));
    check($sformatf("data op%0d a=%h b=%h", op, a, b), resp_data, exp_d);
    check($sformatf("data_mb4 op%0d a=%h b=%h", op, a, b), resp_data4, exp_d);
    check("rd", 64'(resp_rd_addr), 64'(rd));
    check("rd_mb4", 64'(resp_rd_addr4), 64'(rd));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", 64'(resp_valid), 64'd1);
      check("hold_data", resp_data, exp_d);
      check("hold_ready", 64'(req_ready), 64'd0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check("after_busy", 64'(busy), 64'd0);
    check("after_busy4", 64'(busy4), 64'd0);
    check("after_ready", 64'(req_ready), 64'd1);
  endtask

  initial begin
    logic [3:0]  op;
    logic [63:0] a, b;
    logic [4:0]  rd;
    bit          seen;

    rst = 1'b1; req_valid = 1'b0; req_op = '0; req_op1 = '0; req_op2 = '0;
    req_rd_addr = '0; flush = 1'b0; resp_ready = 1'b0;
    @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_req_ready4", 64'(req_ready4), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_resp_valid", 64'(resp_valid), 64'd0);
    check("reset_resp_data", resp_data, 64'd0);
    check("reset_rd", 64'(resp_rd_addr), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_req_ready", 64'(req_ready), 64'd1);

    run_op(4'd0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd9, 64'hFFFF_FFFF_FFFF_FFEB, 65, 17, 0);
    run_op(4'd3, '1, '1, 5'd3, 64'hFFFF_FFFF_FFFF_FFFE, 65, 17, 0);
    run_op(4'd4, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd4, 64'hFFFF_FFFF_FFFF_FFFD, 65, 65, 0);
    run_op(4'd6, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd6, 64'hFFFF_FFFF_FFFF_FFFF, 65, 65, 0);
    run_op(4'd5, 64'd123, 64'd0, 5'd7, 64'hFFFF_FFFF_FFFF_FFFF, 1, 1, 0);
    run_op(4'd6, 64'h8000_0000_0000_0000, '1, 5'd8, 64'd0, 1, 1, 0);
`ifdef YSYX22040228_MULDIV_WORD_EN
    run_op(4'd12, 64'h8000_0000, '1, 5'd10, 64'hFFFF_FFFF_8000_0000, 1, 1, 0);
    run_op(4'd8, 64'hFFFF_FFFF, 64'd2, 5'd14, 64'hFFFF_FFFF_FFFF_FFFE, 33, 9, 0);
`else
    run_op(4'd12, 64'h8000_0000, '1, 5'd10, 64'd0, 1, 1, 0);
    run_op(4'd8, 64'hFFFF_FFFF, 64'd2, 5'd14, 64'd0, 1, 1, 0);
`endif
    run_op(4'd10, 64'd5, 64'd5, 5'd12, 64'd0, 1, 1, 0);
    run_op(4'd5, 64'd100, 64'd7, 5'd11, 64'd14, 65, 65, 5);
    run_op(4'd7, 64'd100, 64'd7, 5'd15, 64'd2, 65, 65, 0);

    // Flush at cycle 10 of a divide.
    req_valid = 1'b1; req_op = 4'd4; req_op1 = 64'd1000; req_op2 = 64'd3; req_rd_addr = 5'd13;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (9) @(negedge clk);
    check("preflush_busy", 64'(busy), 64'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", 64'(busy), 64'd0);
    check("flush_busy4", 64'(busy4), 64'd0);
    seen = 1'b0;
    repeat (80) begin
      if (resp_valid || resp_valid4) seen = 1'b1;
      @(negedge clk);
    end
    check("flush_no_resp", 64'(seen), 64'd0);

    // Request together with flush in IDLE is dropped.
    req_valid = 1'b1; flush = 1'b1; req_op = 4'd0; req_op1 = 64'd3; req_op2 = 64'd4;
    @(negedge clk);
    req_valid = 1'b0; flush = 1'b0;
    check("flush_req_busy", 64'(busy), 64'd0);
    check("flush_req_busy4", 64'(busy4), 64'd0);

    // Reset mid-operation aborts without a response.
    req_valid = 1'b1; req_op = 4'd1; req_op1 = 64'd3; req_op2 = 64'd4;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_abort_busy", 64'(busy), 64'd0);
    seen = 1'b0;
    repeat (70) begin
      if (resp_valid || resp_valid4) seen = 1'b1;
      @(negedge clk);
    end
    check("rst_abort_no_resp", 64'(seen), 64'd0);

    for (int n = 0; n < 40; n++) begin
      op = 4'($urandom_range(0, 15));
      a  = pick();
      b  = pick();
      rd = 5'($urandom);
      run_op(op, a, b, rd, model_res(op, a, b), model_lat(op, a, b, 1), model_lat(op, a, b, 4),
             int'($urandom_range(0, 2)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Iterative RV64M multiply/divide unit for the execute stage. It sits beside the single-cycle ALU and accepts one M-extension operation at a time over a valid/ready request channel. It computes the result over multiple cycles and returns it on a valid/ready response channel. While it holds an operation it raises `busy`, which the pipeline control uses as an execute-stage stall request.

## Interface
Parameters:
- `XLEN`, 64: operand/result width; must be 32 or 64.
- `MUL_BITS`, 1: multiplier bits retired per cycle; one of 1, 2, 4.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit can accept; `(state==IDLE) && !rst`.
- `req_op`  in  4  operation code:
  - 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU
  - 4 DIV, 5 DIVU, 6 REM, 7 REMU
  - 8 MULW
  - 12 DIVW, 13 DIVUW, 14 REMW, 15 REMUW
  - bit3 marks a word op; codes 9–11 are illegal.
- `req_op1`, `req_op2`  in  XLEN  rs1/rs2 values.
- `req_rd_addr`  in  5  destination register.
- `flush`  in  1  kill the in-flight operation (branch/trap redirect).
- `resp_valid`  out  1  result available.
- `resp_ready`  in  1  write-back accepts the result.
- `resp_data`  out  XLEN  result.
- `resp_rd_addr`  out  5  destination register of the result.
- `busy`  out  1  `state != IDLE`; stall request.

## Operation
- States: IDLE, MUL, DIV, DONE.
- Handshake: a request is accepted when `req_valid && req_ready`. Operands, op and rd are latched in that cycle.
- IDLE transitions on accept:
  - MUL codes → MUL.
  - DIV/REM with divisor 0 or signed overflow → DONE directly (special case).
  - Other DIV/REM → DIV.
- Signed handling: operands are converted to magnitudes according to the op's signedness. The result is negated on exit when the signs require it.
- MUL: shift-add over the magnitudes, `MUL_BITS` multiplier bits per cycle.
  - MUL returns product[XLEN-1:0].
  - MULH, MULHSU and MULHU return product[2·XLEN-1:XLEN].
- DIV: restoring, one quotient bit per cycle. The remainder sign follows the dividend.
- Special cases:
  - Divide by zero: quotient = all ones; remainder = dividend.
  - Overflow (most-negative ÷ −1): quotient = dividend; remainder = 0.
- Word ops use op[31:0] only. The 32-bit result is sign-extended to XLEN; this applies to DIVUW and REMUW as well.
- Illegal codes 9–11: go to DONE with result 0.
- DONE: `resp_valid` = 1, and `resp_data`/`resp_rd_addr` stay stable until `resp_ready`. On `resp_valid && resp_ready` → IDLE.
- `flush` (any state) → IDLE next cycle and `resp_valid` cleared. A request presented in the same cycle as `flush` is not accepted.
- Priority: `rst` > `flush` > handshake.

## Timing
- Reset values: `resp_valid`=0, `resp_data`=0, `resp_rd_addr`=0, `busy`=0. `req_ready`=0 during `rst` and 1 in the cycle after reset.
- Accept cycle = cycle 0. `resp_valid` first rises at:
  - Non-word MUL: cycle XLEN/MUL_BITS + 1.
  - MULW: cycle 32/MUL_BITS + 1.
  - Non-word DIV/REM: cycle XLEN + 1.
  - Word DIV/REM: cycle 33.
  - Special cases and illegal codes: cycle 1.
- Sign correction is applied in the transition into DONE; it adds no extra cycle.
- Response consumed at cycle N → `req_ready`=1 at N+1. Minimum issue spacing is latency + 1.
- `busy` is high from cycle 1 until the cycle after the response handshake or the flush.
- A `rst` mid-operation aborts with no response.

## Configuration
- Macro `YSYX22040228_MULDIV_WORD_EN`:
  - Defined: word ops 8 and 12–15 behave as specified above.
  - Undefined: any code with bit3=1 is treated as illegal (result 0 at cycle 1), and the 32-bit datapath mux is removed.
  - Required for XLEN=32 builds to be left undefined.

## Test plan
- Reset, MUL: reset 2 cycles, then MUL op1=7, op2=−3 with XLEN=64, MUL_BITS=1 → `resp_data`=0xFFFF_FFFF_FFFF_FFEB at cycle 65, rd echoed.
- MULHU: op1=op2=0xFFFF_FFFF_FFFF_FFFF → 0xFFFF_FFFF_FFFF_FFFE. Repeat with MUL_BITS=4 → same value at cycle 17.
- DIV/REM: DIV −7 ÷ 2 → −3 at cycle 65; REM −7 ÷ 2 → −1.
- Special cases: DIVU x ÷ 0 → all ones at cycle 1. REM 0x8000_0000_0000_0000 ÷ −1 → 0. DIVW 0x8000_0000 ÷ −1 → 0xFFFF_FFFF_8000_0000 at cycle 1.
- Backpressure: hold `resp_ready`=0 for 5 cycles after `resp_valid` → data stable and `req_ready`=0 throughout; a new request is accepted the cycle after the handshake.
- Flush: assert `flush` at cycle 10 of a DIV → `busy`=0 at cycle 11, no `resp_valid` ever. A simultaneous `req_valid`+`flush` in IDLE is not accepted.
